// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - shared types and geometry constants for the flappy game blocks
package flappy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } game_state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam int SPRITE_H = 32;
    localparam int BIRD_X   = 160;
    localparam int FLOOR_Y  = 448;

    // Packed 4-digit BCD increment with ripple carry; holds at 9999.
    function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        bcd_digit_t  d;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                d = v[i*4 +: 4];
                if (carry) begin
                    if (d == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                        carry       = 1'b1;
                    end else begin
                        r[i*4 +: 4] = d + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// rtl/bcd_counter4.sv - 4-digit BCD counter with clear, increment and 9999 saturation
module bcd_counter4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] count
);
    import flappy_pkg::*;

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Clear has priority over increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 16'h0000;
        end else if (inc) begin
            count_d = bcd4_inc(count_q);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'h0000;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/flappy_game_ctrl.sv
// rtl/flappy_game_ctrl.sv - round sequencer, flap conditioning, collision detect and scoring
module flappy_game_ctrl #(
    parameter int FLOOR_Y         = 448,
    parameter int SPRITE_H        = 32,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DYING_FRAMES    = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        button,
    input  logic        frame_tick,
    input  logic        bright,
    input  logic        sprite_on,
    input  logic        pipe_on,
    input  logic [9:0]  bird_y,
    input  logic        pipe_passed,
    output logic        game_run,
    output logic        world_reset,
    output logic        flap,
    output logic [15:0] score,
    output logic [15:0] high_score,
    output logic [1:0]  state
);
    import flappy_pkg::*;

    localparam int LW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FW = $clog2(DYING_FRAMES + 1);

    logic          btn_s1_q, btn_s1_d;
    logic          btn_s2_q, btn_s2_d;
    logic          btn_s3_q, btn_s3_d;
    logic [LW-1:0] lock_q, lock_d;
    game_state_e   state_q, state_d;
    logic          hit_q, hit_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [15:0]   high_q, high_d;
    logic          game_run_q, game_run_d;
    logic          world_reset_q, world_reset_d;
    logic          flap_q, flap_d;

    logic          accepted;
    logic          collide;
    logic          floor_hit;
    logic [10:0]   floor_sum;
    logic          score_clr;
    logic          score_inc;
    logic [15:0]   score_w;

    // Button synchroniser, edge detect and post-accept lockout.
    always_comb begin
        btn_s1_d = button;
        btn_s2_d = btn_s1_q;
        btn_s3_d = btn_s2_q;
        accepted = btn_s2_q && !btn_s3_q && (lock_q == '0);
        lock_d   = lock_q;
        if (accepted) begin
            lock_d = LW'(DEBOUNCE_CYCLES - 1);
        end else if (lock_q != '0) begin
            lock_d = lock_q - 1'b1;
        end
    end

    // Collision terms; the floor sum is one bit wider than bird_y so it cannot wrap.
    always_comb begin
        collide   = bright && sprite_on && pipe_on;
        floor_sum = {1'b0, bird_y} + 11'(SPRITE_H);
        floor_hit = (floor_sum >= 11'(FLOOR_Y));
        score_inc = pipe_passed && (state_q == ST_PLAY);
    end

    // Round state machine with registered outputs.
    always_comb begin
        state_d       = state_q;
        hit_d         = hit_q;
        fcnt_d        = fcnt_q;
        high_d        = high_q;
        flap_d        = 1'b0;
        world_reset_d = 1'b0;
        score_clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accepted) begin
                    state_d       = ST_PLAY;
                    flap_d        = 1'b1;
                    world_reset_d = 1'b1;
                    score_clr     = 1'b1;
                end
            end
            ST_PLAY: begin
                flap_d = accepted;
                fcnt_d = '0;
                if (frame_tick) begin
                    hit_d = 1'b0;
                    if (hit_q || floor_hit) begin
                        state_d = ST_DYING;
                    end
                end else if (collide) begin
                    hit_d = 1'b1;
                end
            end
            ST_DYING: begin
                if (frame_tick) begin
                    if (fcnt_q == FW'(DYING_FRAMES - 1)) begin
                        state_d = ST_OVER;
                        fcnt_d  = '0;
                        if (score_w > high_q) begin
                            high_d = score_w;
                        end
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (accepted) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        game_run_d = (state_d == ST_PLAY);
    end

    // All control state, cleared asynchronously while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_s1_q      <= 1'b0;
            btn_s2_q      <= 1'b0;
            btn_s3_q      <= 1'b0;
            lock_q        <= '0;
            state_q       <= ST_IDLE;
            hit_q         <= 1'b0;
            fcnt_q        <= '0;
            high_q        <= 16'h0000;
            game_run_q    <= 1'b0;
            world_reset_q <= 1'b0;
            flap_q        <= 1'b0;
        end else begin
            btn_s1_q      <= btn_s1_d;
            btn_s2_q      <= btn_s2_d;
            btn_s3_q      <= btn_s3_d;
            lock_q        <= lock_d;
            state_q       <= state_d;
            hit_q         <= hit_d;
            fcnt_q        <= fcnt_d;
            high_q        <= high_d;
            game_run_q    <= game_run_d;
            world_reset_q <= world_reset_d;
            flap_q        <= flap_d;
        end
    end

    bcd_counter4 u_score (
        .clk   (clk),
        .rst_n (reset),
        .clr   (score_clr),
        .inc   (score_inc),
        .count (score_w)
    );

    assign game_run    = game_run_q;
    assign world_reset = world_reset_q;
    assign flap        = flap_q;
    assign score       = score_w;
    assign high_score  = high_q;
    assign state       = state_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// tb/tb_flappy_game_ctrl.sv - directed self-checking bench for flappy_game_ctrl
module tb_flappy_game_ctrl;

    logic        clk;
    logic        reset;
    logic        button;
    logic        frame_tick;
    logic        bright;
    logic        sprite_on;
    logic        pipe_on;
    logic [9:0]  bird_y;
    logic        pipe_passed;
    logic        game_run;
    logic        world_reset;
    logic        flap;
    logic [15:0] score;
    logic [15:0] high_score;
    logic [1:0]  state;

    int n_checks = 0;
    int n_errors = 0;
    int nf;
    int nw;

    flappy_game_ctrl #(
        .FLOOR_Y         (448),
        .SPRITE_H        (32),
        .DEBOUNCE_CYCLES (8),
        .DYING_FRAMES    (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .button      (button),
        .frame_tick  (frame_tick),
        .bright      (bright),
        .sprite_on   (sprite_on),
        .pipe_on     (pipe_on),
        .bird_y      (bird_y),
        .pipe_passed (pipe_passed),
        .game_run    (game_run),
        .world_reset (world_reset),
        .flap        (flap),
        .score       (score),
        .high_score  (high_score),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic press(input int hold, output int f, output int w);
        f = 0;
        w = 0;
        button = 1'b1;
        repeat (hold) begin
            step();
            f += int'(flap);
            w += int'(world_reset);
        end
        button = 1'b0;
        repeat (12) begin
            step();
            f += int'(flap);
            w += int'(world_reset);
        end
    endtask

    task automatic pipes(input int n);
        pipe_passed = 1'b1;
        repeat (n) step();
        pipe_passed = 1'b0;
        step();
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic collide();
        bright = 1'b1; sprite_on = 1'b1; pipe_on = 1'b1;
        step();
        bright = 1'b0; sprite_on = 1'b0; pipe_on = 1'b0;
        step();
    endtask

    task automatic start_round(input string tag);
        press(1, nf, nw);
        check({tag, "_wr"}, nw, 1);
        check({tag, "_flap"}, nf, 1);
        check({tag, "_state"}, state, 2'd1);
        check({tag, "_score"}, score, 16'h0000);
    endtask

    task automatic dying_to_over(input logic [15:0] exp_high);
        tick();
        tick();
        check("dying_mid", state, 2'd2);
        tick();
        check("over_state", state, 2'd3);
        check("over_high", high_score, exp_high);
        press(1, nf, nw);
        check("over_to_idle", state, 2'd0);
        check("over_no_wr", nw, 0);
    endtask

    initial begin
        reset = 1'b0; button = 1'b0; frame_tick = 1'b0;
        bright = 1'b0; sprite_on = 1'b0; pipe_on = 1'b0;
        bird_y = 10'd100; pipe_passed = 1'b0;
        repeat (3) step();
        check("rst_state", state, 2'd0);
        check("rst_run", game_run, 1'b0);
        check("rst_wr", world_reset, 1'b0);
        check("rst_flap", flap, 1'b0);
        check("rst_score", score, 16'h0000);
        check("rst_high", high_score, 16'h0000);
        reset = 1'b1;
        step();

        // Held button: flap and world_reset three clocks after the edge, once only.
        button = 1'b1;
        step();
        check("lat1_flap", flap, 1'b0);
        step();
        check("lat2_flap", flap, 1'b0);
        step();
        check("lat3_flap", flap, 1'b1);
        check("lat3_wr", world_reset, 1'b1);
        check("lat3_state", state, 2'd1);
        check("lat3_run", game_run, 1'b1);
        nf = 0; nw = 0;
        repeat (40) begin
            step();
            nf += int'(flap);
            nw += int'(world_reset);
        end
        button = 1'b0;
        repeat (12) step();
        check("hold_extra_flap", nf, 0);
        check("hold_extra_wr", nw, 0);

        // Double tap inside the lockout yields one flap; later press yields one more.
        nf = 0;
        button = 1'b1; step(); nf += int'(flap);
        button = 1'b0; step(); nf += int'(flap);
        button = 1'b1; step(); nf += int'(flap);
        button = 1'b0;
        repeat (14) begin step(); nf += int'(flap); end
        check("lockout_flaps", nf, 1);
        press(1, nf, nw);
        check("play_flap", nf, 1);
        check("play_no_wr", nw, 0);

        // Score with BCD carries.
        pipe_passed = 1'b1; step(); pipe_passed = 1'b0;
        check("score_lat", score, 16'h0001);
        step();
        pipes(8);
        check("score_9", score, 16'h0009);
        pipes(1);
        check("score_10", score, 16'h0010);
        pipes(2);
        check("score_12", score, 16'h0012);
        pipes(25);
        check("score_37", score, 16'h0037);

        // Partial overlap is not a hit; full overlap kills at the next frame tick.
        bright = 1'b1; sprite_on = 1'b1; step(); bright = 1'b0; sprite_on = 1'b0; step();
        tick();
        check("partial_play", state, 2'd1);
        collide();
        check("hit_pending", state, 2'd1);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        check("hit_dying", state, 2'd2);
        check("hit_run", game_run, 1'b0);
        step();
        press(1, nf, nw);
        check("dying_no_flap", nf, 0);
        pipes(1);
        check("dying_no_score", score, 16'h0037);
        dying_to_over(16'h0037);

        // Floor boundary, plus pipe_passed coincident with the fatal tick.
        start_round("r2");
        pipes(41);
        bird_y = 10'd415;
        tick();
        check("floor_415", state, 2'd1);
        bird_y = 10'd416;
        frame_tick = 1'b1; pipe_passed = 1'b1; step();
        frame_tick = 1'b0; pipe_passed = 1'b0;
        check("floor_416", state, 2'd2);
        check("coincident_score", score, 16'h0042);
        step();
        bird_y = 10'd100;
        dying_to_over(16'h0042);

        // Lower score keeps the high score.
        start_round("r3");
        pipes(10);
        collide();
        tick();
        check("r3_dying", state, 2'd2);
        dying_to_over(16'h0042);

        // Saturation at 9999.
        start_round("r4");
        pipes(100);
        check("score_100", score, 16'h0100);
        pipes(9898);
        check("score_9998", score, 16'h9998);
        pipes(3);
        check("score_9999", score, 16'h9999);
        collide();
        tick();
        dying_to_over(16'h9999);

        // Asynchronous reset mid-round.
        start_round("r5");
        pipes(5);
        check("r5_score", score, 16'h0005);
        #3;
        reset = 1'b0;
        #1;
        check("async_state", state, 2'd0);
        check("async_score", score, 16'h0000);
        check("async_high", high_score, 16'h0000);
        check("async_run", game_run, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/flappy_game_ctrl.md
# flappy_game_ctrl

Game-level sequencer for the Flappy Bird VGA design. It owns the round state machine (title, play, dying, game over) and conditions the flap button into single pulses. It detects bird/pipe and bird/floor collisions from the pixel stream, and keeps the BCD score and high score. It sits beside the pixel-colour block, driving the physics and pipe enables and consuming per-pixel sprite/pipe hits.

## Interface
Parameters:
- FLOOR_Y, 448: bird_y + SPRITE_H at or beyond this value is a floor crash
- SPRITE_H, 32: bird sprite height in lines
- DEBOUNCE_CYCLES, 250000: lockout after an accepted flap; 2.5 ms at 100 MHz
- DYING_FRAMES, 60: frame ticks spent in DYING before OVER

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low; all state cleared while low
- button  in  1  raw, asynchronous flap button
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- bright  in  1  pixel in visible area
- sprite_on  in  1  current pixel is an opaque bird pixel
- pipe_on  in  1  current pixel is a pipe pixel
- bird_y  in  10  bird top row, unsigned
- pipe_passed  in  1  one-cycle pulse when a pipe's trailing edge crosses the bird column
- game_run  out  1  enable for physics and pipe scrolling
- world_reset  out  1  one-cycle pulse that re-initialises physics and pipes
- flap  out  1  one-cycle conditioned flap pulse
- score  out  16  4-digit BCD current score
- high_score  out  16  4-digit BCD best score since reset
- state  out  2  IDLE=0, PLAY=1, DYING=2, OVER=3

## Operation
- Button conditioning:
  - 2-FF synchroniser, then rising-edge detect.
  - An edge is accepted only when the lockout counter is 0; acceptance reloads the counter to DEBOUNCE_CYCLES-1.
  - A held button produces exactly one accepted edge.
- IDLE:
  - game_run=0.
  - An accepted edge pulses world_reset and flap in the same cycle, clears score, and moves to PLAY.
- PLAY:
  - game_run=1. Accepted edges drive flap.
  - hit latch sets on any cycle with bright & sprite_on & pipe_on.
  - On frame_tick, if hit=1 or bird_y+SPRITE_H ≥ FLOOR_Y, go to DYING. hit clears on every frame_tick.
  - The floor sum is computed at 11 bits, so there is no wrap.
- DYING:
  - game_run=0; accepted edges are ignored and flap stays 0.
  - A frame counter counts frame_ticks. At DYING_FRAMES, go to OVER.
  - On that same transition, high_score ← score if score > high_score. Plain 16-bit unsigned compare is valid for packed BCD.
- OVER:
  - game_run=0.
  - An accepted edge moves to IDLE. world_reset is not pulsed here; it fires on IDLE→PLAY.
- Score:
  - Increments by 1 in BCD on pipe_passed, only in PLAY.
  - Carries across digits (0009→0010, 0099→0100) and saturates at 9999.
- Simultaneous events:
  - pipe_passed in the same cycle as a frame_tick that causes PLAY→DYING is counted.
  - A flap in the same cycle as the death transition is forwarded (state is still PLAY).

## Timing
- Reset values:
  - state=IDLE; game_run=0, world_reset=0, flap=0, score=0, high_score=0.
  - Lockout counter, hit latch and frame counter are 0.
- Flap latency: a rising edge on button produces flap 3 clk later (2 sync stages plus edge register), registered.
- State transitions and all outputs are registered; they take effect the cycle after the causing event.
- Score updates the cycle after pipe_passed.
- Collision-to-DYING latency: up to one frame, because it is evaluated only at frame_tick.
- Reset asserted mid-round returns to IDLE immediately and clears high_score.

## Structure
- Shared package flappy_pkg holds:
  - the state enum (2-bit);
  - the BCD digit type;
  - SPRITE_H, BIRD_X, FLOOR_Y constants, shared with the pixel-colour block and the physics block.
- One natural sub-module, bcd_counter4: 4-digit increment with clear and saturate at 9999.
- The button conditioner stays inline.

## Test plan
- Reset, then hold button 10 ms → exactly one world_reset and one flap. flap appears 3 clk after the edge; state=PLAY, game_run=1.
- PLAY with 12 pipe_passed pulses → score=16'h0012. Preset to 9998 plus 3 pulses → score=16'h9999.
- Assert bright&sprite_on&pipe_on for 1 cycle mid-frame → DYING the cycle after the next frame_tick; game_run=0. Button presses during DYING produce no flap.
- Set bird_y=416 with SPRITE_H=32, then frame_tick → DYING. bird_y=415 → stays PLAY.
- Score 0042 and high 0037 → after DYING_FRAMES ticks, state=OVER and high_score=16'h0042. A next round ending at 0010 leaves high_score=16'h0042.
- Drop reset during PLAY with score 0005 → state=IDLE, score=0, high_score=0 immediately, with no clock needed.
